// File: rtl/demux_2_pkg.sv
// Shared types and constants for the demux_2_stream packet router.
//   demux_2_state_t : packet FSM state (IDLE between packets, BUSY mid-packet)
//   SEL_0 / SEL_1   : destination encodings for select_i / the latched target
package demux_2_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} demux_2_state_t;

  localparam logic SEL_0 = 1'b0;
  localparam logic SEL_1 = 1'b1;

endpackage

// File: rtl/demux_2_stream_if.sv
// Valid/ready stream bundle used for the router input and both outputs.
//   data  : payload, DATA_WIDTH bits
//   last  : final beat of a packet
//   valid : beat present (driven by the master)
//   ready : beat consumed when valid & ready (driven by the slave)
interface demux_2_stream_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, output last, output valid, input ready);
  modport slave  (input data, input last, input valid, output ready);

endinterface

// File: rtl/demux_2_slot.sv
// One-entry output register for one router destination.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   load_i            : capture data_i/last_i and mark the slot full
//   drain_i           : downstream ready; empties the slot when not loading
//   data_i, last_i    : beat to capture
//   valid_o, data_o,
//   last_o            : registered slot contents, drive the output directly
module demux_2_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  // Load has priority over drain so a full slot can be refilled in the
  // same cycle it is consumed, keeping one beat per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/demux_2_stream.sv
// Packet-aware registered 1-to-2 stream router.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   select_i     : destination, sampled on the first beat of each packet only
//   in_if        : input stream (slave); in_if.ready is the accept gate
//   out0_if      : destination 0 stream (master), registered
//   out1_if      : destination 1 stream (master), registered
// The destination chosen on a packet's first beat is held until its last
// beat. Each destination owns a one-entry slot, so a stalled destination
// only blocks packets aimed at it.
module demux_2_stream
  import demux_2_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               select_i,
  demux_2_stream_if.slave    in_if,
  demux_2_stream_if.master   out0_if,
  demux_2_stream_if.master   out1_if
);

  demux_2_state_t state_q, state_d;
  logic           sel_q, sel_d;

  logic target;
  logic target_valid;
  logic target_ready;
  logic in_ready;
  logic accept;
  logic load_0;
  logic load_1;
  logic slot_valid_0;
  logic slot_valid_1;

  // Destination: live select between packets, latched select mid-packet.
  assign target       = (state_q == IDLE) ? select_i : sel_q;
  assign target_valid = (target == SEL_1) ? slot_valid_1 : slot_valid_0;
  assign target_ready = (target == SEL_1) ? out1_if.ready : out0_if.ready;

  // Only the target slot gates input; the other slot may be stalled freely.
  assign in_ready    = !target_valid | target_ready;
  assign in_if.ready = in_ready;
  assign accept      = in_if.valid & in_ready;

  assign load_0 = accept & (target == SEL_0);
  assign load_1 = accept & (target == SEL_1);

  // Packet FSM: enter BUSY on a non-final first beat, leave on the last beat.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_if.last) begin
          state_d = BUSY;
          sel_d   = select_i;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (accept && in_if.last) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and latched destination registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= SEL_0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  demux_2_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_0),
    .drain_i (out0_if.ready),
    .data_i  (in_if.data),
    .last_i  (in_if.last),
    .valid_o (slot_valid_0),
    .data_o  (out0_if.data),
    .last_o  (out0_if.last)
  );

  demux_2_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_1),
    .drain_i (out1_if.ready),
    .data_i  (in_if.data),
    .last_i  (in_if.last),
    .valid_o (slot_valid_1),
    .data_o  (out1_if.data),
    .last_o  (out1_if.last)
  );

  assign out0_if.valid = slot_valid_0;
  assign out1_if.valid = slot_valid_1;

endmodule
